player_input_controller: RTL and testbench

//  Turns per-frame vision results (lane 0-2, jump, data_valid) and three manual buttons into
//  one-step game commands (LEFT/RIGHT/JUMP). Issues them over a valid/ready handshake to the game FSM.

---
 rtl/player_input_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_player_input_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/player_input_controller.sv
// Player input controller: filters per-frame vision results and manual buttons into
// single-step LEFT/RIGHT/JUMP commands delivered over a valid/ready handshake.
module player_input_controller #(
   parameter int LANE_STABLE_FRAMES = 3,
   parameter int JUMP_STABLE_FRAMES = 2,
   parameter int OVERRIDE_FRAMES    = 30,
   parameter int TIMEOUT_CYCLES     = 1000000
) (
   input  logic       pixel_clock_in,
   input  logic       reset_n_in,
   input  logic [1:0] vis_lane,
   input  logic       vis_jump,
   input  logic       vis_data_valid,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [1:0] cmd_type,
   output logic       cmd_manual,
   output logic [1:0] cur_lane,
   output logic       vision_locked
);

   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int OVR_W = $clog2(OVERRIDE_FRAMES + 1);
   localparam int RUN_W = $clog2(LANE_STABLE_FRAMES + 1);
   localparam int JMP_W = $clog2(JUMP_STABLE_FRAMES + 1);

   localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [OVR_W-1:0] OVR_MAX = OVR_W'(OVERRIDE_FRAMES);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LANE_STABLE_FRAMES);
   localparam logic [JMP_W-1:0] JMP_MAX = JMP_W'(JUMP_STABLE_FRAMES);

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LEFT  = 2'd1;
   localparam logic [1:0] CMD_RIGHT = 2'd2;
   localparam logic [1:0] CMD_JUMP  = 2'd3;

   typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t           state, state_next;
   logic             vld_d, frame_evt, timeout, vis_ok, manual_accept;
   logic [2:0]       btn_now, btn_d, btn_rise, btn_pend, clr_btn;
   logic [WD_W-1:0]  wd_cnt;
   logic [OVR_W-1:0] ovr_cnt;
   logic [1:0]       prev_lane, target_lane, lane_next, type_next, sel_type;
   logic [RUN_W-1:0] lane_run, run_next;
   logic [JMP_W-1:0] jmp_cnt, jmp_next;
   logic             jmp_armed, jump_pend, lane_hit, jump_hit, clr_vjump;
   logic             valid_next, manual_next, sel_go, sel_manual;

   // Button vector is ordered {jump, left, right} so priority follows bit position.
   assign btn_now       = {btn_jump, btn_left, btn_right};
   assign btn_rise      = btn_now & ~btn_d;
   assign frame_evt     = vis_data_valid & ~vld_d;
   assign timeout       = (wd_cnt == WD_MAX);
   assign vis_ok        = vision_locked && (ovr_cnt == OVR_W'(0));
   assign manual_accept = (state == ISSUE) && cmd_ready && cmd_manual;
   assign lane_hit      = frame_evt && (run_next == RUN_MAX);
   assign jump_hit      = frame_evt && vis_jump && (jmp_next == JMP_MAX) && jmp_armed;

   // Edge-detect history, watchdog and override counter.
   always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         vld_d         <= 1'b0;
         btn_d         <= 3'b000;
         wd_cnt        <= WD_W'(0);
         vision_locked <= 1'b0;
         ovr_cnt       <= OVR_W'(0);
      end else begin
         vld_d <= vis_data_valid;
         btn_d <= btn_now;
         if (frame_evt) begin
            wd_cnt        <= WD_W'(0);
            vision_locked <= 1'b1;
         end else if (!timeout) begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_LAST) vision_locked <= 1'b0;
         end else begin
            vision_locked <= 1'b0;
         end
         if (manual_accept) ovr_cnt <= OVR_MAX;
         else if (frame_evt && (ovr_cnt != OVR_W'(0))) ovr_cnt <= ovr_cnt - OVR_W'(1);
      end
   end

   // Next values of the lane run and jump run counters for the current frame result.
   always_comb begin
      run_next = lane_run;
      jmp_next = jmp_cnt;
      if (vis_lane == 2'd3) run_next = RUN_W'(0);
      else if (vis_lane == prev_lane) run_next = (lane_run == RUN_MAX) ? RUN_MAX : lane_run + RUN_W'(1);
      else run_next = RUN_W'(1);
      if (!vis_jump) jmp_next = JMP_W'(0);
      else jmp_next = (jmp_cnt == JMP_MAX) ? JMP_MAX : jmp_cnt + JMP_W'(1);
   end

   // Frame filters; a watchdog timeout wipes them so stale runs never complete.
   always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         prev_lane <= 2'd3;
         lane_run  <= RUN_W'(0);
         jmp_cnt   <= JMP_W'(0);
         jmp_armed <= 1'b1;
      end else if (frame_evt) begin
         prev_lane <= vis_lane;
         lane_run  <= run_next;
         jmp_cnt   <= jmp_next;
         jmp_armed <= ~vis_jump | (jmp_armed & (jmp_next != JMP_MAX));
      end else if (timeout) begin
         prev_lane <= 2'd3;
         lane_run  <= RUN_W'(0);
         jmp_cnt   <= JMP_W'(0);
         jmp_armed <= 1'b1;
      end
   end

   // Pending sources; manual acceptance also kills a same-time vision jump.
   always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         btn_pend    <= 3'b000;
         jump_pend   <= 1'b0;
         target_lane <= 2'd1;
      end else begin
         btn_pend <= btn_rise | (btn_pend & ~clr_btn);
         if (manual_accept || !vis_ok) jump_pend <= 1'b0;
         else if (jump_hit) jump_pend <= 1'b1;
         else if (clr_vjump) jump_pend <= 1'b0;
         if (manual_accept) target_lane <= lane_next;
         else if (!vis_ok) target_lane <= cur_lane;
         else if (lane_hit) target_lane <= vis_lane;
      end
   end

   // Command FSM: source selection in IDLE, handshake and lane step in ISSUE.
   always_comb begin
      state_next  = state;
      valid_next  = cmd_valid;
      type_next   = cmd_type;
      manual_next = cmd_manual;
      lane_next   = cur_lane;
      clr_btn     = 3'b000;
      clr_vjump   = 1'b0;
      sel_go      = 1'b0;
      sel_type    = CMD_NONE;
      sel_manual  = 1'b0;
      case (state)
         IDLE: begin
            if (btn_pend[2]) begin
               clr_btn[2] = 1'b1;
               sel_go     = 1'b1;
               sel_type   = CMD_JUMP;
               sel_manual = 1'b1;
            end else if (btn_pend[1]) begin
               clr_btn[1] = 1'b1;
               sel_go     = (cur_lane != 2'd0);
               sel_type   = CMD_LEFT;
               sel_manual = 1'b1;
            end else if (btn_pend[0]) begin
               clr_btn[0] = 1'b1;
               sel_go     = (cur_lane != 2'd2);
               sel_type   = CMD_RIGHT;
               sel_manual = 1'b1;
            end else if (vis_ok && jump_pend) begin
               clr_vjump = 1'b1;
               sel_go    = 1'b1;
               sel_type  = CMD_JUMP;
            end else if (vis_ok && (target_lane < cur_lane)) begin
               sel_go   = 1'b1;
               sel_type = CMD_LEFT;
            end else if (vis_ok && (target_lane > cur_lane)) begin
               sel_go   = 1'b1;
               sel_type = CMD_RIGHT;
            end else begin
               sel_go = 1'b0;
            end
            if (sel_go) begin
               valid_next  = 1'b1;
               type_next   = sel_type;
               manual_next = sel_manual;
               state_next  = ISSUE;
            end else begin
               valid_next = 1'b0;
            end
         end
         ISSUE: begin
            if (cmd_ready) begin
               valid_next  = 1'b0;
               type_next   = CMD_NONE;
               manual_next = 1'b0;
               state_next  = IDLE;
               case (cmd_type)
                  CMD_LEFT:  lane_next = cur_lane - 2'd1;
                  CMD_RIGHT: lane_next = cur_lane + 2'd1;
                  default:   lane_next = cur_lane;
               endcase
            end else begin
               state_next = ISSUE;
            end
         end
         default: begin
            state_next  = IDLE;
            valid_next  = 1'b0;
            type_next   = CMD_NONE;
            manual_next = 1'b0;
         end
      endcase
   end

   // FSM state and registered command outputs.
   always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state      <= IDLE;
         cmd_valid  <= 1'b0;
         cmd_type   <= CMD_NONE;
         cmd_manual <= 1'b0;
         cur_lane   <= 2'd1;
      end else begin
         state      <= state_next;
         cmd_valid  <= valid_next;
         cmd_type   <= type_next;
         cmd_manual <= manual_next;
         cur_lane   <= lane_next;
      end
   end

endmodule

// File: tb/tb_player_input_controller.sv
// Directed self-checking bench for player_input_controller (short watchdog timeout).
module tb_player_input_controller;

   logic       pixel_clock_in = 1'b0;
   logic       reset_n_in;
   logic [1:0] vis_lane;
   logic       vis_jump, vis_data_valid;
   logic       btn_left, btn_right, btn_jump, cmd_ready;
   logic       cmd_valid, cmd_manual, vision_locked;
   logic [1:0] cmd_type, cur_lane;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0] hs_type [0:63];
   logic       hs_man  [0:63];
   int         hs_n = 0;

   always #5 pixel_clock_in = ~pixel_clock_in;

   player_input_controller #(
      .LANE_STABLE_FRAMES(3),
      .JUMP_STABLE_FRAMES(2),
      .OVERRIDE_FRAMES(30),
      .TIMEOUT_CYCLES(200)
   ) dut (
      .pixel_clock_in(pixel_clock_in),
      .reset_n_in(reset_n_in),
      .vis_lane(vis_lane),
      .vis_jump(vis_jump),
      .vis_data_valid(vis_data_valid),
      .btn_left(btn_left),
      .btn_right(btn_right),
      .btn_jump(btn_jump),
      .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid),
      .cmd_type(cmd_type),
      .cmd_manual(cmd_manual),
      .cur_lane(cur_lane),
      .vision_locked(vision_locked)
   );

   // Log every completed handshake.
   always @(posedge pixel_clock_in) begin
      if (reset_n_in && cmd_valid && cmd_ready && (hs_n < 64)) begin
         hs_type[hs_n] <= cmd_type;
         hs_man[hs_n]  <= cmd_manual;
         hs_n          <= hs_n + 1;
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One frame: valid low for two cycles, then a rising edge with buttons {jump,left,right}.
   task automatic frame(input logic [1:0] lane, input logic jump, input logic [2:0] btns);
      @(negedge pixel_clock_in);
      vis_lane       = lane;
      vis_jump       = jump;
      vis_data_valid = 1'b0;
      repeat (2) @(negedge pixel_clock_in);
      vis_data_valid = 1'b1;
      {btn_jump, btn_left, btn_right} = btns;
      repeat (6) @(negedge pixel_clock_in);
      {btn_jump, btn_left, btn_right} = 3'b000;
   endtask

   task automatic press(input logic [2:0] btns);
      @(negedge pixel_clock_in);
      {btn_jump, btn_left, btn_right} = btns;
      repeat (6) @(negedge pixel_clock_in);
      {btn_jump, btn_left, btn_right} = 3'b000;
      repeat (2) @(negedge pixel_clock_in);
   endtask

   initial begin
      vis_lane       = 2'd3;
      vis_jump       = 1'b0;
      vis_data_valid = 1'b0;
      {btn_jump, btn_left, btn_right} = 3'b000;
      cmd_ready      = 1'b1;
      reset_n_in     = 1'b0;
      repeat (3) @(negedge pixel_clock_in);
      check_value("rst_valid", 32'(cmd_valid), 32'd0);
      check_value("rst_type", 32'(cmd_type), 32'd0);
      check_value("rst_manual", 32'(cmd_manual), 32'd0);
      check_value("rst_lane", 32'(cur_lane), 32'd1);
      check_value("rst_locked", 32'(vision_locked), 32'd0);
      reset_n_in = 1'b1;

      // Three stable lane-2 frames: one vision RIGHT
      for (int i = 0; i < 3; i++) frame(2'd2, 1'b0, 3'b000);
      check_value("t1_count", 32'(hs_n), 32'd1);
      check_value("t1_type", 32'(hs_type[0]), 32'd2);
      check_value("t1_manual", 32'(hs_man[0]), 32'd0);
      check_value("t1_lane", 32'(cur_lane), 32'd2);
      check_value("t1_locked", 32'(vision_locked), 32'd1);

      // Back to lane 1, then 0,0,2,0,0,0 gives LEFT only on the sixth frame
      for (int i = 0; i < 3; i++) frame(2'd1, 1'b0, 3'b000);
      check_value("t2_prep_count", 32'(hs_n), 32'd2);
      check_value("t2_prep_lane", 32'(cur_lane), 32'd1);
      frame(2'd0, 1'b0, 3'b000);
      frame(2'd0, 1'b0, 3'b000);
      frame(2'd2, 1'b0, 3'b000);
      frame(2'd0, 1'b0, 3'b000);
      frame(2'd0, 1'b0, 3'b000);
      check_value("t2_quiet", 32'(hs_n), 32'd2);
      frame(2'd0, 1'b0, 3'b000);
      check_value("t2_count", 32'(hs_n), 32'd3);
      check_value("t2_type", 32'(hs_type[2]), 32'd1);
      check_value("t2_lane", 32'(cur_lane), 32'd0);

      // Two-step moves, then a held LEFT under backpressure
      for (int i = 0; i < 3; i++) frame(2'd2, 1'b0, 3'b000);
      check_value("t3_up_count", 32'(hs_n), 32'd5);
      check_value("t3_up_lane", 32'(cur_lane), 32'd2);
      cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) frame(2'd0, 1'b0, 3'b000);
      for (int i = 0; i < 5; i++) begin
         @(negedge pixel_clock_in);
         check_value("t3_hold", 32'({cmd_valid, cmd_type, cmd_manual}), 32'b1010);
      end
      check_value("t3_hold_lane", 32'(cur_lane), 32'd2);
      cmd_ready = 1'b1;
      repeat (6) @(negedge pixel_clock_in);
      check_value("t3_count", 32'(hs_n), 32'd7);
      check_value("t3_type_a", 32'(hs_type[5]), 32'd1);
      check_value("t3_type_b", 32'(hs_type[6]), 32'd1);
      check_value("t3_lane", 32'(cur_lane), 32'd0);

      // Button jump coincides with the vision jump; vision then ignored for 30 frames
      frame(2'd0, 1'b1, 3'b000);
      frame(2'd0, 1'b1, 3'b100);
      check_value("t4_count", 32'(hs_n), 32'd8);
      check_value("t4_type", 32'(hs_type[7]), 32'd3);
      check_value("t4_manual", 32'(hs_man[7]), 32'd1);
      check_value("t4_lane", 32'(cur_lane), 32'd0);
      frame(2'd2, 1'b0, 3'b000);
      frame(2'd2, 1'b1, 3'b000);
      frame(2'd2, 1'b1, 3'b000);
      for (int i = 0; i < 27; i++) frame(2'd1, 1'b0, 3'b000);
      check_value("t4_override", 32'(hs_n), 32'd8);
      frame(2'd1, 1'b0, 3'b000);
      check_value("t4_resume_count", 32'(hs_n), 32'd9);
      check_value("t4_resume_type", 32'(hs_type[8]), 32'd2);
      check_value("t4_resume_manual", 32'(hs_man[8]), 32'd0);
      check_value("t4_resume_lane", 32'(cur_lane), 32'd1);

      // No frame edges: watchdog drops lock, buttons still work
      @(negedge pixel_clock_in);
      vis_lane = 2'd0;
      repeat (210) @(negedge pixel_clock_in);
      check_value("t5_unlocked", 32'(vision_locked), 32'd0);
      check_value("t5_quiet", 32'(hs_n), 32'd9);
      press(3'b001);
      check_value("t5_count", 32'(hs_n), 32'd10);
      check_value("t5_type", 32'(hs_type[9]), 32'd2);
      check_value("t5_manual", 32'(hs_man[9]), 32'd1);
      check_value("t5_lane", 32'(cur_lane), 32'd2);
      check_value("t5_still_unlocked", 32'(vision_locked), 32'd0);
      frame(2'd0, 1'b0, 3'b000);
      check_value("t5_relock", 32'(vision_locked), 32'd1);

      // RIGHT at the edge lane is dropped; reset mid-ISSUE discards the command
      press(3'b001);
      check_value("t6_edge_count", 32'(hs_n), 32'd10);
      check_value("t6_edge_valid", 32'(cmd_valid), 32'd0);
      check_value("t6_edge_lane", 32'(cur_lane), 32'd2);
      cmd_ready = 1'b0;
      press(3'b010);
      check_value("t6_issue", 32'({cmd_valid, cmd_type, cmd_manual}), 32'b1011);
      #2 reset_n_in = 1'b0;
      #1;
      check_value("t6_rst_valid", 32'(cmd_valid), 32'd0);
      check_value("t6_rst_type", 32'(cmd_type), 32'd0);
      check_value("t6_rst_manual", 32'(cmd_manual), 32'd0);
      check_value("t6_rst_lane", 32'(cur_lane), 32'd1);
      check_value("t6_rst_locked", 32'(vision_locked), 32'd0);
      @(negedge pixel_clock_in);
      cmd_ready  = 1'b1;
      reset_n_in = 1'b1;
      repeat (5) @(negedge pixel_clock_in);
      check_value("t6_post_valid", 32'(cmd_valid), 32'd0);
      check_value("t6_post_lane", 32'(cur_lane), 32'd1);
      check_value("t6_post_count", 32'(hs_n), 32'd10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
